// File: rtl/sx_pkg.sv
// Shared types for the destination router: route-table entry layout, FSM states
// and the single-entry match rule.
package sx_pkg;

    localparam int SX_KEY_MAX  = 32;
    localparam int SX_DEST_MAX = 8;

    typedef struct packed {
        logic                   en;
        logic [SX_KEY_MAX-1:0]  key;
        logic [SX_KEY_MAX-1:0]  mask;
        logic [SX_DEST_MAX-1:0] dest;
    } sx_route_entry_t;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } sx_rt_state_t;

    // An entry whose destination is outside the crossbar never matches.
    function automatic logic sx_key_hit(input sx_route_entry_t e,
                                        input logic [SX_KEY_MAX-1:0] key,
                                        input logic [SX_DEST_MAX-1:0] dest_limit);
        return e.en && (((key ^ e.key) & e.mask) == '0) && (e.dest < dest_limit);
    endfunction

endpackage

// File: rtl/sx_dest_router_table.sv
// Programmable match table: registered entries with a one-entry-per-cycle write
// port and a combinational lowest-index-wins lookup against the stored contents.
module sx_route_table
    import sx_pkg::*;
#(
    parameter int KEY_WIDTH    = 8,
    parameter int M_DATA_COUNT = 10,
    parameter int TABLE_DEPTH  = 8,
    localparam int DEST_WIDTH  = $clog2(M_DATA_COUNT),
    localparam int AW          = $clog2(TABLE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_wr_i,
    input  logic [AW-1:0]         cfg_addr_i,
    input  logic                  cfg_en_i,
    input  logic [KEY_WIDTH-1:0]  cfg_key_i,
    input  logic [KEY_WIDTH-1:0]  cfg_mask_i,
    input  logic [DEST_WIDTH-1:0] cfg_dest_i,
    input  logic [KEY_WIDTH-1:0]  lookup_key_i,
    output logic                  hit_o,
    output logic [DEST_WIDTH-1:0] dest_o
);

    sx_route_entry_t        r_table [TABLE_DEPTH];
    logic [SX_KEY_MAX-1:0]  w_key_ext;
    logic [SX_DEST_MAX-1:0] w_dest_wide;
    logic                   w_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (cfg_wr_i && (int'(cfg_addr_i) < TABLE_DEPTH)) begin
            r_table[cfg_addr_i] <= '{en:   cfg_en_i,
                                     key:  SX_KEY_MAX'(cfg_key_i),
                                     mask: SX_KEY_MAX'(cfg_mask_i),
                                     dest: SX_DEST_MAX'(cfg_dest_i)};
        end
    end

    assign w_key_ext = SX_KEY_MAX'(lookup_key_i);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        w_hit       = 1'b0;
        w_dest_wide = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (sx_key_hit(r_table[i], w_key_ext, SX_DEST_MAX'(M_DATA_COUNT))) begin
                w_hit       = 1'b1;
                w_dest_wide = r_table[i].dest;
            end
        end
    end

    assign hit_o  = w_hit;
    assign dest_o = DEST_WIDTH'(w_dest_wide);

endmodule

// File: rtl/sx_dest_router.sv
// Ingress router: looks up the head beat of each packet, stamps tdest on every
// beat through a single output register, and silently drops unmatched packets.
module sx_dest_router
    import sx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int M_DATA_COUNT = 10,
    parameter int KEY_LSB      = 0,
    parameter int KEY_WIDTH    = 8,
    parameter int TABLE_DEPTH  = 8,
    parameter int CNT_WIDTH    = 16,
    localparam int DEST_WIDTH  = $clog2(M_DATA_COUNT),
    localparam int AW          = $clog2(TABLE_DEPTH),
    localparam int KW          = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_data_i,
    input  logic [KW-1:0]         s_axis_keep_i,
    input  logic                  s_axis_last_i,
    input  logic                  s_axis_valid_i,
    output logic                  s_axis_ready_o,
    output logic [DATA_WIDTH-1:0] m_axis_data_o,
    output logic [DEST_WIDTH-1:0] m_axis_dest_o,
    output logic [KW-1:0]         m_axis_keep_o,
    output logic                  m_axis_last_o,
    output logic                  m_axis_valid_o,
    input  logic                  m_axis_ready_i,
    input  logic                  cfg_wr_i,
    input  logic [AW-1:0]         cfg_addr_i,
    input  logic                  cfg_en_i,
    input  logic [KEY_WIDTH-1:0]  cfg_key_i,
    input  logic [KEY_WIDTH-1:0]  cfg_mask_i,
    input  logic [DEST_WIDTH-1:0] cfg_dest_i,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o,
    output sx_rt_state_t          dbg_state_o
);

    // Handshake: a beat moves on a rising clk edge where valid && ready; valid and
    // payload are held by the sender until taken, and ready never waits on valid.

    sx_rt_state_t          r_state, w_next;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [DEST_WIDTH-1:0] r_m_dest;
    logic [KW-1:0]         r_m_keep;
    logic                  r_m_last;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    logic [KEY_WIDTH-1:0]  w_key;
    logic                  w_hit;
    logic [DEST_WIDTH-1:0] w_hit_dest;
    logic                  w_out_free;
    logic                  w_ready;
    logic                  w_fwd;
    logic                  w_drop;
    logic [DEST_WIDTH-1:0] w_fwd_dest;

    assign w_key = s_axis_data_i[KEY_LSB +: KEY_WIDTH];

    sx_route_table #(
        .KEY_WIDTH   (KEY_WIDTH),
        .M_DATA_COUNT(M_DATA_COUNT),
        .TABLE_DEPTH (TABLE_DEPTH)
    ) u_table (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_wr_i    (cfg_wr_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_en_i    (cfg_en_i),
        .cfg_key_i   (cfg_key_i),
        .cfg_mask_i  (cfg_mask_i),
        .cfg_dest_i  (cfg_dest_i),
        .lookup_key_i(w_key),
        .hit_o       (w_hit),
        .dest_o      (w_hit_dest)
    );

    assign w_out_free = !r_m_valid || m_axis_ready_i;

    // A head that misses is consumed even when the output register is occupied.
    always_comb begin
        w_next = r_state;
        w_ready = w_out_free;
        w_fwd  = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            HEAD: begin
                w_ready = w_out_free || !w_hit;
                if (s_axis_valid_i && w_ready) begin
                    if (w_hit) begin
                        w_fwd = 1'b1;
                        if (!s_axis_last_i) w_next = PASS;
                    end else begin
                        w_drop = 1'b1;
                        if (!s_axis_last_i) w_next = DROP;
                    end
                end
            end
            PASS: begin
                if (s_axis_valid_i && w_out_free) begin
                    w_fwd = 1'b1;
                    if (s_axis_last_i) w_next = HEAD;
                end
            end
            DROP: begin
                w_ready = 1'b1;
                if (s_axis_valid_i && s_axis_last_i) w_next = HEAD;
            end
            default: w_next = HEAD;
        endcase
    end

    assign w_fwd_dest = (r_state == HEAD) ? w_hit_dest : r_dest;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= HEAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_dest  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_dest    <= '0;
        end else begin
            if (w_fwd) begin
                r_m_valid <= 1'b1;
                r_m_data  <= s_axis_data_i;
                r_m_dest  <= w_fwd_dest;
                r_m_keep  <= s_axis_keep_i;
                r_m_last  <= s_axis_last_i;
            end else if (m_axis_ready_i) begin
                r_m_valid <= 1'b0;
            end
            if (w_fwd && (r_state == HEAD)) begin
                r_dest <= w_hit_dest;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign s_axis_ready_o = w_ready;
    assign m_axis_valid_o = r_m_valid;
    assign m_axis_data_o  = r_m_data;
    assign m_axis_dest_o  = r_m_dest;
    assign m_axis_keep_o  = r_m_keep;
    assign m_axis_last_o  = r_m_last;
    assign drop_cnt_o     = r_drop_cnt;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_sx_dest_router.sv
// Randomised bench for sx_dest_router: a packet-level reference model predicts
// each forwarded beat, the input ready, the output valid and the drop count.
module tb_sx_dest_router;
    import sx_pkg::*;

    localparam int DW = 8;
    localparam int DESTW = 4;
    localparam int BW = DW + DESTW + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]    s_data = '0;
    logic             s_keep = 1'b0;
    logic             s_last = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [DW-1:0]    m_data;
    logic [DESTW-1:0] m_dest;
    logic             m_keep;
    logic             m_last;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [2:0]       cfg_addr = '0;
    logic             cfg_en = 1'b0;
    logic [7:0]       cfg_key = '0;
    logic [7:0]       cfg_mask = '0;
    logic [DESTW-1:0] cfg_dest = '0;
    logic [15:0]      drop_cnt;
    sx_rt_state_t     dbg_state;

    sx_dest_router dut (
        .clk(clk), .reset_n(reset_n),
        .s_axis_data_i(s_data), .s_axis_keep_i(s_keep), .s_axis_last_i(s_last),
        .s_axis_valid_i(s_valid), .s_axis_ready_o(s_ready),
        .m_axis_data_o(m_data), .m_axis_dest_o(m_dest), .m_axis_keep_o(m_keep),
        .m_axis_last_o(m_last), .m_axis_valid_o(m_valid), .m_axis_ready_i(m_ready),
        .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr), .cfg_en_i(cfg_en), .cfg_key_i(cfg_key),
        .cfg_mask_i(cfg_mask), .cfg_dest_i(cfg_dest), .drop_cnt_o(drop_cnt),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_total = 0;
    int n_bad = 0;
    logic [BW-1:0] exp_q[$];

    bit         t_en[8];
    logic [7:0] t_key[8];
    logic [7:0] t_mask[8];
    logic [3:0] t_dest[8];
    bit         in_fwd = 0;
    bit         in_drop = 0;
    logic [3:0] cur_dest = '0;
    int         m_drops = 0;

    // stimulus state
    int         pkt_left = 0;
    bit         first_beat = 0;
    bit         held = 0;
    bit         gen_pkts = 0;
    int         ready_pct = 100;
    bit         cfg_rand = 0;
    logic [7:0] key_pool[4];
    bit         cfg_req = 0;
    logic [2:0] req_addr;
    logic       req_en;
    logic [7:0] req_key, req_mask;
    logic [3:0] req_dest;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            if (t_en[i] && (((k ^ t_key[i]) & t_mask[i]) == 8'h00) && (t_dest[i] < 4'd10))
                return i;
        end
        return -1;
    endfunction

    function automatic logic [BW-1:0] beat(input logic [7:0] d, input logic [3:0] ds,
                                           input logic k, input logic l);
        return {d, ds, k, l};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            t_en[i] = 0; t_key[i] = '0; t_mask[i] = '0; t_dest[i] = '0;
        end
        exp_q.delete();
        in_fwd = 0; in_drop = 0; m_drops = 0;
        pkt_left = 0; held = 0; first_beat = 0;
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        bit occ;
        bit exp_ready;
        int idx;
        @(negedge clk);
        if (!held) begin
            if (pkt_left == 0 && gen_pkts && $urandom_range(0, 99) < 70) begin
                pkt_left = $urandom_range(1, 5);
                first_beat = 1;
            end
            if (pkt_left > 0 && $urandom_range(0, 99) < 80) begin
                s_valid = 1'b1;
                if (first_beat && $urandom_range(0, 99) < 65)
                    s_data = key_pool[$urandom_range(0, 3)];
                else
                    s_data = 8'($urandom_range(0, 255));
                s_keep = 1'($urandom_range(0, 1));
                s_last = (pkt_left == 1);
            end else begin
                s_valid = 1'b0;
            end
        end
        m_ready = ($urandom_range(0, 99) < ready_pct);
        if (cfg_req) begin
            cfg_wr = 1'b1; cfg_addr = req_addr; cfg_en = req_en;
            cfg_key = req_key; cfg_mask = req_mask; cfg_dest = req_dest;
            cfg_req = 0;
        end else if (cfg_rand && $urandom_range(0, 99) < 10) begin
            cfg_wr = 1'b1;
            cfg_addr = 3'($urandom_range(0, 7));
            cfg_en = ($urandom_range(0, 99) < 80);
            cfg_key = key_pool[$urandom_range(0, 3)];
            case ($urandom_range(0, 3))
                0: cfg_mask = 8'hFF;
                1: cfg_mask = 8'hF0;
                2: cfg_mask = 8'h00;
                default: cfg_mask = 8'($urandom_range(0, 255));
            endcase
            cfg_dest = 4'($urandom_range(0, 15));
        end else begin
            cfg_wr = 1'b0;
        end
        #1;
        occ = (exp_q.size() != 0);
        chk("m_valid", m_valid, occ);
        chk("drop_cnt", drop_cnt, 64'(m_drops));
        if (occ) begin
            chk("m_beat", {m_data, m_dest, m_keep, m_last}, exp_q[0]);
            if (m_ready) void'(exp_q.pop_front());
        end
        if (s_valid) begin
            idx = lookup(s_data);
            exp_ready = in_drop || !occ || m_ready || (!in_fwd && idx < 0);
            chk("s_ready", s_ready, exp_ready);
            if (s_ready) begin
                if (in_fwd) begin
                    exp_q.push_back(beat(s_data, cur_dest, s_keep, s_last));
                    if (s_last) in_fwd = 0;
                end else if (in_drop) begin
                    if (s_last) in_drop = 0;
                end else if (idx >= 0) begin
                    exp_q.push_back(beat(s_data, t_dest[idx], s_keep, s_last));
                    cur_dest = t_dest[idx];
                    in_fwd = !s_last;
                end else begin
                    if (m_drops < 65535) m_drops++;
                    in_drop = !s_last;
                end
                pkt_left--;
                first_beat = 0;
                held = 0;
            end else begin
                held = 1;
            end
        end else begin
            held = 0;
        end
        // the write lands at this edge, after the lookup above
        if (cfg_wr) begin
            t_en[cfg_addr] = cfg_en; t_key[cfg_addr] = cfg_key;
            t_mask[cfg_addr] = cfg_mask; t_dest[cfg_addr] = cfg_dest;
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic e, input logic [7:0] k,
                             input logic [7:0] m, input logic [3:0] d);
        req_addr = a; req_en = e; req_key = k; req_mask = m; req_dest = d;
        cfg_req = 1;
        step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, m_valid, 1'b0);
        chk({tag, "_data"}, {m_data, m_dest, m_keep, m_last}, '0);
        chk({tag, "_drop"}, drop_cnt, 16'd0);
        chk({tag, "_state"}, dbg_state, HEAD);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;

        // single routed entry, output always ready
        key_pool[0] = 8'h12; key_pool[1] = 8'h12; key_pool[2] = 8'h13; key_pool[3] = 8'h92;
        cfg_write(3'd0, 1'b1, 8'h12, 8'hFF, 4'd3);
        gen_pkts = 1; ready_pct = 100;
        run(300);

        // nothing enabled: every packet dropped, then a matching packet passes again
        gen_pkts = 0; run(20);
        for (int i = 0; i < 8; i++) cfg_write(3'(i), 1'b0, 8'h00, 8'h00, 4'd0);
        gen_pkts = 1; ready_pct = 50;
        run(200);
        gen_pkts = 0; run(20);
        cfg_write(3'd0, 1'b1, 8'h12, 8'hFF, 4'd3);
        gen_pkts = 1; run(100);

        // priority between overlapping entries, plus an out-of-range destination
        gen_pkts = 0; run(20);
        cfg_write(3'd0, 1'b0, 8'h00, 8'h00, 4'd0);
        cfg_write(3'd1, 1'b1, 8'h10, 8'hF0, 4'd5);
        cfg_write(3'd4, 1'b1, 8'h15, 8'hFF, 4'd7);
        cfg_write(3'd2, 1'b1, 8'h20, 8'h00, 4'd12);
        key_pool[0] = 8'h15; key_pool[1] = 8'h1A; key_pool[2] = 8'h25; key_pool[3] = 8'h10;
        gen_pkts = 1; ready_pct = 50;
        run(400);

        // random table rewrites during traffic with back-pressure
        key_pool[0] = 8'h12; key_pool[1] = 8'h15; key_pool[2] = 8'h3C; key_pool[3] = 8'hA0;
        cfg_rand = 1;
        run(2000);
        cfg_rand = 0;

        // reset in the middle of a forwarded packet
        for (int i = 0; i < 8; i++) cfg_write(3'(i), 1'b1, 8'h00, 8'h00, 4'(i));
        begin
            int budget = 300;
            while (!in_fwd && budget > 0) begin
                step();
                budget--;
            end
            chk("mid_pkt_reached", in_fwd, 1'b1);
        end
        @(negedge clk);
        reset_n = 1'b0;
        s_valid = 1'b0; cfg_wr = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_hold");
        reset_n = 1'b1;
        ready_pct = 70;
        run(300);

        gen_pkts = 0;
        run(30);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
